// File: rtl/icache_pkg.sv
// Shared icache definitions: FSM state encodings and the default geometry
// agreed with the instruction memory.
package icache_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int BLOCK_SIZE = 8;
    localparam int MEM_SIZE   = 32;
    localparam int NUM_LINES  = 8;

    typedef enum logic [1:0] {
        ICACHE_IDLE = 2'd0,
        ICACHE_MISS = 2'd1,
        ICACHE_FILL = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_line_store.sv
// Line storage for the icache: valid/tag/data arrays with a combinational read
// port and a synchronous write port; valid bits clear asynchronously on reset.
module icache_line_store #(
    parameter int WORD_SIZE  = icache_pkg::WORD_SIZE,
    parameter int BLOCK_SIZE = icache_pkg::BLOCK_SIZE,
    parameter int NUM_LINES  = icache_pkg::NUM_LINES,
    parameter int TAG_W      = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [$clog2(NUM_LINES)-1:0]        rd_index,
    output logic                                rd_valid,
    output logic [TAG_W-1:0]                    rd_tag,
    output logic [WORD_SIZE*BLOCK_SIZE-1:0]     rd_block,
    input  logic                                we,
    input  logic [$clog2(NUM_LINES)-1:0]        wr_index,
    input  logic [TAG_W-1:0]                    wr_tag,
    input  logic [WORD_SIZE*BLOCK_SIZE-1:0]     wr_block
);
    import icache_pkg::*;

    localparam int LINE_W = WORD_SIZE * BLOCK_SIZE;

    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [LINE_W-1:0]    data_r [NUM_LINES];

    // Valid bits: only a completed refill may set one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else if (we) begin
            valid_r[wr_index] <= 1'b1;
        end
    end

    // Tag and data payload; meaningless until the matching valid bit is set.
    always_ff @(posedge clock) begin
        if (we) begin
            tag_r[wr_index]  <= wr_tag;
            data_r[wr_index] <= wr_block;
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_block = data_r[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only L1 instruction cache with blocking refill.
// Define ICACHE_STATS_EN to build the saturating hit/miss counters.
module icache #(
    parameter int WORD_SIZE  = icache_pkg::WORD_SIZE,
    parameter int BLOCK_SIZE = icache_pkg::BLOCK_SIZE,
    parameter int MEM_SIZE   = icache_pkg::MEM_SIZE,
    parameter int NUM_LINES  = icache_pkg::NUM_LINES
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            cpu_ren,
    input  logic [$clog2(MEM_SIZE)+$clog2(BLOCK_SIZE)-1:0]  cpu_addr,
    output logic [WORD_SIZE-1:0]                            cpu_dout,
    output logic                                            cpu_stall,
    output logic                                            mem_ren,
    output logic [$clog2(MEM_SIZE)-1:0]                     mem_block_address,
    input  logic                                            mem_ready,
    input  logic [WORD_SIZE*BLOCK_SIZE-1:0]                 mem_din,
    output logic [15:0]                                     hit_count,
    output logic [15:0]                                     miss_count
);
    import icache_pkg::*;

    localparam int OFF_W  = $clog2(BLOCK_SIZE);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int BA_W   = $clog2(MEM_SIZE);
    localparam int TAG_W  = BA_W - IDX_W;
    localparam int ADDR_W = BA_W + OFF_W;
    localparam int LINE_W = WORD_SIZE * BLOCK_SIZE;

    icache_state_e state_r, next_state_s;

    logic              mem_ren_r, mem_ren_next_s;
    logic [BA_W-1:0]   mem_block_address_r, mem_addr_next_s;
    logic              line_we_s;
    logic              rd_valid_s;
    logic [TAG_W-1:0]  rd_tag_s;
    logic [LINE_W-1:0] rd_block_s;
    logic              hit_s;
    logic [WORD_SIZE-1:0] word_s;

    logic [OFF_W-1:0]  addr_off_s;
    logic [IDX_W-1:0]  addr_idx_s;
    logic [TAG_W-1:0]  addr_tag_s;
    logic [BA_W-1:0]   addr_blk_s;

    assign addr_off_s = cpu_addr[OFF_W-1:0];
    assign addr_idx_s = cpu_addr[OFF_W +: IDX_W];
    assign addr_tag_s = cpu_addr[ADDR_W-1 -: TAG_W];
    assign addr_blk_s = cpu_addr[ADDR_W-1:OFF_W];

    icache_line_store #(
        .WORD_SIZE  (WORD_SIZE),
        .BLOCK_SIZE (BLOCK_SIZE),
        .NUM_LINES  (NUM_LINES),
        .TAG_W      (TAG_W)
    ) u_line_store (
        .clock    (clock),
        .reset    (reset),
        .rd_index (addr_idx_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_block (rd_block_s),
        .we       (line_we_s),
        .wr_index (mem_block_address_r[IDX_W-1:0]),
        .wr_tag   (mem_block_address_r[BA_W-1 -: TAG_W]),
        .wr_block (mem_din)
    );

    assign hit_s  = rd_valid_s && (rd_tag_s == addr_tag_s);
    assign word_s = rd_block_s[addr_off_s * WORD_SIZE +: WORD_SIZE];

    // State and memory-port registers; reset drops an in-flight fetch at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r             <= ICACHE_IDLE;
            mem_ren_r           <= 1'b0;
            mem_block_address_r <= {BA_W{1'b0}};
        end else begin
            state_r             <= next_state_s;
            mem_ren_r           <= mem_ren_next_s;
            mem_block_address_r <= mem_addr_next_s;
        end
    end

    // Next state, CPU response and refill control.
    always_comb begin
        next_state_s    = state_r;
        cpu_stall       = 1'b1;
        cpu_dout        = {WORD_SIZE{1'b0}};
        line_we_s       = 1'b0;
        mem_ren_next_s  = 1'b0;
        mem_addr_next_s = mem_block_address_r;
        case (state_r)
            ICACHE_IDLE: begin
                cpu_stall = cpu_ren & ~hit_s;
                if (cpu_ren && hit_s) begin
                    cpu_dout = word_s;
                end else begin
                    cpu_dout = {WORD_SIZE{1'b0}};
                end
                if (cpu_ren && !hit_s) begin
                    next_state_s    = ICACHE_MISS;
                    mem_ren_next_s  = 1'b1;
                    mem_addr_next_s = addr_blk_s;
                end else begin
                    next_state_s    = ICACHE_IDLE;
                end
            end
            ICACHE_MISS: begin
                // The fill always uses the address latched at miss detection.
                if (mem_ready) begin
                    line_we_s      = 1'b1;
                    mem_ren_next_s = 1'b0;
                    next_state_s   = ICACHE_FILL;
                end else begin
                    mem_ren_next_s = 1'b1;
                    next_state_s   = ICACHE_MISS;
                end
            end
            ICACHE_FILL: begin
                // One low cycle on ren lets the memory rearm its delay counter.
                next_state_s = ICACHE_IDLE;
            end
            default: begin
                next_state_s = ICACHE_IDLE;
            end
        endcase
    end

    assign mem_ren           = mem_ren_r;
    assign mem_block_address = mem_block_address_r;

`ifdef ICACHE_STATS_EN
    logic        hit_event_s, miss_event_s;
    logic [15:0] hit_count_r, miss_count_r;

    assign hit_event_s  = (state_r == ICACHE_IDLE) && cpu_ren && hit_s;
    assign miss_event_s = (state_r == ICACHE_IDLE) && cpu_ren && !hit_s;

    // Saturating hit/miss counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count_r  <= 16'd0;
            miss_count_r <= 16'd0;
        end else begin
            if (hit_event_s && (hit_count_r != 16'hFFFF)) begin
                hit_count_r <= hit_count_r + 16'd1;
            end
            if (miss_event_s && (miss_count_r != 16'hFFFF)) begin
                miss_count_r <= miss_count_r + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: refill timeline, hits, conflicts,
// stray mem_ready, address change during a miss and reset mid-miss.
module tb_icache;

    logic         clock;
    logic         reset;
    logic         cpu_ren;
    logic [7:0]   cpu_addr;
    logic [31:0]  cpu_dout;
    logic         cpu_stall;
    logic         mem_ren;
    logic [4:0]   mem_block_address;
    logic         mem_ready;
    logic [255:0] mem_din;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

`ifdef ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int exp_hits = 0;

    icache dut (
        .clock             (clock),
        .reset             (reset),
        .cpu_ren           (cpu_ren),
        .cpu_addr          (cpu_addr),
        .cpu_dout          (cpu_dout),
        .cpu_stall         (cpu_stall),
        .mem_ren           (mem_ren),
        .mem_block_address (mem_block_address),
        .mem_ready         (mem_ready),
        .mem_din           (mem_din),
        .hit_count         (hit_count),
        .miss_count        (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Block b holds words ((b+1) << 8) + k, so block 0 is 0x100..0x107.
    function automatic logic [255:0] make_block(input logic [4:0] blk);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) begin
            b[k*32 +: 32] = ((32'(blk) + 32'd1) << 8) + 32'(k);
        end
        return b;
    endfunction

    // Starts at a negedge in IDLE with a missing address; ends in IDLE, #1 past negedge.
    task automatic miss_fill(input logic [7:0] addr, input logic [4:0] blk);
        cpu_ren  = 1'b1;
        cpu_addr = addr;
        #1;
        check("miss_stall", 32'(cpu_stall), 32'd1);
        @(negedge clock);
        check("miss_mem_ren", 32'(mem_ren), 32'd1);
        check("miss_block_addr", 32'(mem_block_address), 32'(blk));
        @(negedge clock);
        check("miss_wait_stall", 32'(cpu_stall), 32'd1);
        mem_ready = 1'b1;
        mem_din   = make_block(blk);
        @(negedge clock);
        mem_ready = 1'b0;
        mem_din   = make_block(5'd30);
        check("fill_mem_ren", 32'(mem_ren), 32'd0);
        check("fill_stall", 32'(cpu_stall), 32'd1);
        @(negedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        cpu_ren   = 1'b1;
        cpu_addr  = 8'h00;
        mem_ready = 1'b0;
        mem_din   = 256'd0;
        @(negedge clock);
        @(negedge clock);
        #1;
        check("rst_stall", 32'(cpu_stall), 32'd1);
        check("rst_mem_ren", 32'(mem_ren), 32'd0);
        check("rst_block_addr", 32'(mem_block_address), 32'd0);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        check("rst_miss_count", 32'(miss_count), 32'd0);
        cpu_ren = 1'b0;
        reset   = 1'b1;
        @(negedge clock);

        // Cold miss on block 0, then the refilled word is served.
        miss_fill(8'h00, 5'd0);
        check("first_hit_stall", 32'(cpu_stall), 32'd0);
        check("first_hit_dout", cpu_dout, 32'h100);
        exp_hits++;
        @(negedge clock);

        // Sequential hits through the rest of line 0.
        for (int i = 1; i < 8; i++) begin
            cpu_addr = 8'(i);
            #1;
            check("seq_stall", 32'(cpu_stall), 32'd0);
            check("seq_dout", cpu_dout, 32'h100 + 32'(i));
            check("seq_mem_ren", 32'(mem_ren), 32'd0);
            exp_hits++;
            @(negedge clock);
        end

        // Conflict on index 0: block 8 evicts block 0, then block 0 returns.
        miss_fill(8'h40, 5'd8);
        check("conflict_dout", cpu_dout, 32'h900);
        exp_hits++;
        @(negedge clock);
        miss_fill(8'h00, 5'd0);
        check("refetch_dout", cpu_dout, 32'h100);
        exp_hits++;
        @(negedge clock);
        cpu_ren = 1'b0;
        #1;
        check("idle_stall", 32'(cpu_stall), 32'd0);
        check("idle_dout", cpu_dout, 32'd0);
        check("miss_count", 32'(miss_count), STATS ? 32'd3 : 32'd0);
        check("hit_count", 32'(hit_count), STATS ? 32'(exp_hits) : 32'd0);

        // Stray mem_ready in IDLE must not write any line.
        mem_ready = 1'b1;
        mem_din   = make_block(5'd31);
        @(negedge clock);
        mem_ready = 1'b0;
        #1;
        check("stray_mem_ren", 32'(mem_ren), 32'd0);
        miss_fill(8'h08, 5'd1);
        check("line1_dout", cpu_dout, 32'h200);
        @(negedge clock);
        cpu_addr = 8'h00;
        #1;
        check("line0_kept_stall", 32'(cpu_stall), 32'd0);
        check("line0_kept_dout", cpu_dout, 32'h100);
        @(negedge clock);

        // Address change mid-miss: block 2 still fills line 2.
        cpu_addr = 8'h10;
        #1;
        check("sw_stall", 32'(cpu_stall), 32'd1);
        @(negedge clock);
        check("sw_block_addr", 32'(mem_block_address), 32'd2);
        cpu_addr = 8'h20;
        @(negedge clock);
        check("sw_held_addr", 32'(mem_block_address), 32'd2);
        check("sw_held_ren", 32'(mem_ren), 32'd1);
        mem_ready = 1'b1;
        mem_din   = make_block(5'd2);
        @(negedge clock);
        mem_ready = 1'b0;
        check("sw_fill_ren", 32'(mem_ren), 32'd0);
        @(negedge clock);
        cpu_addr = 8'h10;
        #1;
        check("sw_line2_stall", 32'(cpu_stall), 32'd0);
        check("sw_line2_dout", cpu_dout, 32'h300);
        @(negedge clock);
        cpu_addr = 8'h20;
        #1;
        check("sw_new_miss", 32'(cpu_stall), 32'd1);
        @(negedge clock);
        check("sw_new_ren", 32'(mem_ren), 32'd1);
        check("sw_new_block", 32'(mem_block_address), 32'd4);

        // Reset mid-miss drops ren immediately and clears all lines.
        reset = 1'b0;
        #1;
        check("rst_mid_ren", 32'(mem_ren), 32'd0);
        check("rst_mid_addr", 32'(mem_block_address), 32'd0);
        check("rst_mid_stall", 32'(cpu_stall), 32'd1);
        @(negedge clock);
        reset   = 1'b1;
        cpu_ren = 1'b0;
        #1;
        check("rst_mid_hits", 32'(hit_count), 32'd0);
        check("rst_mid_misses", 32'(miss_count), 32'd0);
        @(negedge clock);
        miss_fill(8'h00, 5'd0);
        check("post_rst_dout", cpu_dout, 32'h100);
        check("post_rst_misses", 32'(miss_count), STATS ? 32'd1 : 32'd0);
        cpu_ren = 1'b0;
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
